id_hazard_unit: RTL and testbench

ID_HAZARD_UNIT -- requirements
Module: id_hazard_unit

---
 rtl/pipeline_pkg.sv | 21 ++
 rtl/hazard_slot_match.sv | 21 ++
 rtl/id_hazard_unit.sv | 99 +++++++++
 tb/tb_id_hazard_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the decode-stage hazard logic.
// Contents: destination-tracker slot type, tracker depth, register-zero constant.
package pipeline_pkg;

    localparam int unsigned NUM_TRACK_SLOTS = 3;
    localparam logic [4:0]  REG_ZERO        = 5'd0;

    // Tracker positions, oldest last.
    localparam int unsigned SLOT_IX  = 0;
    localparam int unsigned SLOT_MEM = 1;
    localparam int unsigned SLOT_WB  = 2;

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       is_load;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

endpackage

// File: rtl/hazard_slot_match.sv
// Compares one source register of the decoding instruction against one tracker slot.
// Ports:
//   slot   in  tracker slot contents (valid, dest, is_load)
//   src    in  source register number
//   used   in  instruction actually reads src
//   hit    out slot will write src; register 0 never matches
module hazard_slot_match
    import pipeline_pkg::*;
(
    input  slot_t      slot,
    input  logic [4:0] src,
    input  logic       used,
    output logic       hit
);

    logic unused_load;

    assign unused_load = slot.is_load;
    assign hit = used && slot.valid && (slot.dest == src) && (src != REG_ZERO);

endmodule

// File: rtl/id_hazard_unit.sv
// Decode-stage RAW hazard detector with a 3-deep destination tracker (IX, MEM, WB).
// State advances on the falling clock edge, in step with the pipeline registers.
// Optional feature: define HAZARD_FORWARDING_EN to stall only on load-use in IX;
// without it any pending writer of a source register stalls decode.
// Ports:
//   clk, rst               clock (falling-edge state), async active-high reset
//   id_valid               decode holds a real instruction
//   rs_in, rt_in           source registers; uses_rs / uses_rt qualify them
//   dest_in                resolved destination; write_to_reg_in, is_load_in qualify it
//   flush_in               kill the instruction in decode (wins over stall)
//   stall_out              freeze PC, IF/ID and ID/IX
//   stall_cycles           saturating count of stalled cycles since reset
module id_hazard_unit
    import pipeline_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  rs_in,
    input  logic [4:0]  rt_in,
    input  logic        uses_rs,
    input  logic        uses_rt,
    input  logic [4:0]  dest_in,
    input  logic        write_to_reg_in,
    input  logic        is_load_in,
    input  logic        flush_in,
    output logic        stall_out,
    output logic [15:0] stall_cycles
);

    slot_t                      trk_q [NUM_TRACK_SLOTS];
    slot_t                      trk_d [NUM_TRACK_SLOTS];
    logic [15:0]                stall_cycles_q;
    logic [15:0]                stall_cycles_d;
    logic [NUM_TRACK_SLOTS-1:0] rs_hit;
    logic [NUM_TRACK_SLOTS-1:0] rt_hit;
    logic                       any_hazard;

    for (genvar s = 0; s < NUM_TRACK_SLOTS; s++) begin : g_match
        hazard_slot_match u_rs_match (
            .slot (trk_q[s]),
            .src  (rs_in),
            .used (uses_rs),
            .hit  (rs_hit[s])
        );
        hazard_slot_match u_rt_match (
            .slot (trk_q[s]),
            .src  (rt_in),
            .used (uses_rt),
            .hit  (rt_hit[s])
        );
    end

    always_comb begin
        any_hazard = 1'b0;
`ifdef HAZARD_FORWARDING_EN
        // Older producers are forwarded; only a load still in IX has no data yet.
        any_hazard = (rs_hit[SLOT_IX] || rt_hit[SLOT_IX]) && trk_q[SLOT_IX].is_load;
`else
        any_hazard = |(rs_hit | rt_hit);
`endif
    end

    assign stall_out    = id_valid && !flush_in && any_hazard;
    assign stall_cycles = stall_cycles_q;

    always_comb begin
        for (int unsigned i = 1; i < NUM_TRACK_SLOTS; i++) begin
            trk_d[i] = trk_q[i-1];
        end
        // A stalled or flushed instruction leaves a bubble, so a stall drains itself.
        trk_d[SLOT_IX] = SLOT_EMPTY;
        if (id_valid && !stall_out && !flush_in && write_to_reg_in && (dest_in != REG_ZERO)) begin
            trk_d[SLOT_IX].valid   = 1'b1;
            trk_d[SLOT_IX].dest    = dest_in;
            trk_d[SLOT_IX].is_load = is_load_in;
        end

        stall_cycles_d = stall_cycles_q;
        if (stall_out && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_TRACK_SLOTS; i++) begin
                trk_q[i] <= SLOT_EMPTY;
            end
            stall_cycles_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_TRACK_SLOTS; i++) begin
                trk_q[i] <= trk_d[i];
            end
            stall_cycles_q <= stall_cycles_d;
        end
    end

endmodule

// File: tb/tb_id_hazard_unit.sv
module tb_id_hazard_unit;

`ifdef HAZARD_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [4:0]  rs_in;
    logic [4:0]  rt_in;
    logic        uses_rs;
    logic        uses_rt;
    logic [4:0]  dest_in;
    logic        write_to_reg_in;
    logic        is_load_in;
    logic        flush_in;
    logic        stall_out;
    logic [15:0] stall_cycles;

    int n_chk  = 0;
    int n_fail = 0;

    id_hazard_unit dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .rs_in           (rs_in),
        .rt_in           (rt_in),
        .uses_rs         (uses_rs),
        .uses_rt         (uses_rt),
        .dest_in         (dest_in),
        .write_to_reg_in (write_to_reg_in),
        .is_load_in      (is_load_in),
        .flush_in        (flush_in),
        .stall_out       (stall_out),
        .stall_cycles    (stall_cycles)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    // Writer cycle fields, reader cycle fields, expected reader stall per build.
    typedef struct {
        string      name;
        logic [4:0] w_dest;
        logic       w_wr;
        logic       w_ld;
        logic       r_valid;
        logic [4:0] r_rs;
        logic [4:0] r_rt;
        logic       r_urs;
        logic       r_urt;
        logic       r_flush;
        logic       exp_nofwd;
        logic       exp_fwd;
    } vec_t;

    vec_t vt [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic [4:0] d,
                         input logic wr, input logic ld, input logic fl);
        id_valid        = v;
        rs_in           = rs;
        rt_in           = rt;
        uses_rs         = urs;
        uses_rt         = urt;
        dest_in         = d;
        write_to_reg_in = wr;
        is_load_in      = ld;
        flush_in        = fl;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Advance one pipeline step; leaves time just after the falling edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Reset pulsed between falling edges.
    task automatic do_reset();
        idle();
        rst = 1'b1;
        #3;
        rst = 1'b0;
        #1;
    endtask

    // Writer, then a reader of rr held in decode until it stops stalling.
    task automatic run_pair(input string name, input logic [4:0] wd, input logic wl,
                            input logic [4:0] rr, input int exp_n);
        int  n;
        bit  done;
        do_reset();
        chk({name, "_cnt_after_rst"}, 32'(stall_cycles), 32'd0);
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, wd, 1'b1, wl, 1'b0);
        #1;
        chk({name, "_writer_stall"}, 32'(stall_out), 32'd0);
        tick();
        drive(1'b1, rr, 5'd0, 1'b1, 1'b0, 5'd20, 1'b1, 1'b0, 1'b0);
        n    = 0;
        done = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (!stall_out) begin
                done = 1'b1;
                break;
            end
            n++;
            tick();
        end
        chk({name, "_drained"}, 32'(done), 32'd1);
        chk({name, "_stall_len"}, 32'(n), 32'(exp_n));
        chk({name, "_stall_cnt"}, 32'(stall_cycles), 32'(exp_n));
        tick();
        idle();
    endtask

    initial begin
        int   exp_stalls;
        int   pat_err;
        int   decreased;
        logic exp_s;
        logic [15:0] prev_cnt;

        vt[0] = '{"raw_rs",      5'd3,  1'b1, 1'b0, 1'b1, 5'd3,  5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[1] = '{"load_rt",     5'd5,  1'b1, 1'b1, 1'b1, 5'd0,  5'd5,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vt[2] = '{"rt_unused",   5'd5,  1'b1, 1'b1, 1'b1, 5'd0,  5'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[3] = '{"reg_zero",    5'd0,  1'b1, 1'b1, 1'b1, 5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[4] = '{"no_write",    5'd7,  1'b0, 1'b0, 1'b1, 5'd7,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[5] = '{"id_invalid",  5'd9,  1'b1, 1'b1, 1'b0, 5'd9,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[6] = '{"flush_wins",  5'd9,  1'b1, 1'b1, 1'b1, 5'd9,  5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[7] = '{"independent", 5'd12, 1'b1, 1'b0, 1'b1, 5'd1,  5'd2,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[8] = '{"both_r31",    5'd31, 1'b1, 1'b1, 1'b1, 5'd31, 5'd31, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

        idle();
        rst = 1'b1;
        #12;
        chk("rst_stall", 32'(stall_out), 32'd0);
        chk("rst_cnt", 32'(stall_cycles), 32'd0);
        rst = 1'b0;
        #1;

        // Table vectors: writer cycle, reader cycle, then drain.
        foreach (vt[i]) begin
            drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, vt[i].w_dest, vt[i].w_wr, vt[i].w_ld, 1'b0);
            #1;
            chk({vt[i].name, "_w"}, 32'(stall_out), 32'd0);
            tick();
            drive(vt[i].r_valid, vt[i].r_rs, vt[i].r_rt, vt[i].r_urs, vt[i].r_urt,
                  5'd0, 1'b0, 1'b0, vt[i].r_flush);
            #1;
            chk({vt[i].name, "_r"}, 32'(stall_out), 32'(FWD ? vt[i].exp_fwd : vt[i].exp_nofwd));
            tick();
            idle();
            tick();
            tick();
            tick();
        end

        // Dependent add, then load-use, then ALU-to-ALU.
        run_pair("add_sub_r3", 5'd3, 1'b0, 5'd3, FWD ? 0 : 3);
        run_pair("lw_add_r5",  5'd5, 1'b1, 5'd5, FWD ? 1 : 3);
        run_pair("add_add_r5", 5'd5, 1'b0, 5'd5, FWD ? 0 : 3);
        run_pair("wr_r0",      5'd0, 1'b1, 5'd0, 0);

        // Flush with a hazard present: no stall, no count, flushed load never tracked.
        do_reset();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b1);
        #1;
        chk("flush_stall", 32'(stall_out), 32'd0);
        tick();
        chk("flush_cnt", 32'(stall_cycles), 32'd0);
        drive(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("flush_ix_bubble", 32'(stall_out), 32'd0);
        tick();
        idle();
        tick();
        tick();
        tick();

        // Asynchronous reset in the middle of a stall.
        do_reset();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("midrst_pre_stall", 32'(stall_out), 32'd1);
        tick();
        chk("midrst_pre_cnt", 32'(stall_cycles), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_stall", 32'(stall_out), 32'd0);
        chk("midrst_cnt", 32'(stall_cycles), 32'd0);
        rst = 1'b0;
        #1;
        chk("midrst_after_stall", 32'(stall_out), 32'd0);
        tick();
        chk("midrst_after_cnt", 32'(stall_cycles), 32'd0);

        // Saturation: an instruction that loads r1 and reads r1 stalls on itself.
        // Without forwarding it stalls 3 of every 4 cycles, with forwarding 1 of 2.
        do_reset();
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b1, 1'b0);
        exp_stalls = 0;
        pat_err    = 0;
        decreased  = 0;
        prev_cnt   = stall_cycles;
        for (int k = 0; k < 88000; k++) begin
            exp_s = FWD ? ((k % 2) != 0) : ((k % 4) != 0);
            if (stall_out !== exp_s) pat_err++;
            if (exp_s) exp_stalls++;
            tick();
            if (stall_cycles < prev_cnt) decreased++;
            prev_cnt = stall_cycles;
        end
        chk("sat_pattern_errs", 32'(pat_err), 32'd0);
        chk("sat_no_wrap", 32'(decreased), 32'd0);
        chk("sat_cnt", 32'(stall_cycles), (exp_stalls > 65535) ? 32'd65535 : 32'(exp_stalls));
        tick();
        chk("sat_hold", 32'(stall_cycles), (exp_stalls >= 65535) ? 32'd65535 : 32'(exp_stalls + (FWD ? 0 : 1)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
